// File: rtl/mul_div_unit_pkg.sv
// Operation and FSM state encodings shared by the iterative multiply/divide unit.
package mul_div_unit_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_CALC = 2'd1;
   localparam logic [1:0] MD_FIX  = 2'd2;

   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic is_div_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mul_div_unit_negate.sv
// md_negate: combinational conditional two's-complement negator. carry_in lets two
// instances be chained into a wider negation (upper half takes carry when lower half is zero).
module md_negate #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         neg,
   input  logic         carry_in,
   output logic [W-1:0] result
);

   assign result = neg ? (~value + {{(W-1){1'b0}}, carry_in}) : value;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO writes.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int N  = 32,
   parameter int CW = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] inA,
   input  logic [N-1:0] inB,
   input  logic         hi_wen,
   input  logic         lo_wen,
   input  logic [N-1:0] wd,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);

   logic [1:0]     state_reg;
   logic [CW-1:0]  count_reg;
   logic [1:0]     op_reg;
   logic           sdiff_reg, aneg_reg, dz_reg, done_reg;
   logic [2*N-1:0] acc_reg, mcand_reg;
   logic [N-1:0]   mplier_reg, hi_reg, lo_reg;

   logic           a_neg, b_neg;
   logic [N-1:0]   mag_a, mag_b;

   assign a_neg = is_signed_op(op) & inA[N-1];
   assign b_neg = is_signed_op(op) & inB[N-1];

   md_negate #(.W(N)) u_neg_a (.value(inA), .neg(a_neg), .carry_in(1'b1), .result(mag_a));
   md_negate #(.W(N)) u_neg_b (.value(inB), .neg(b_neg), .carry_in(1'b1), .result(mag_b));

   // Divide keeps remainder in acc upper half and shifts quotient bits into the lower half.
   logic [N:0]     div_diff;
   logic [2*N-1:0] acc_step;
   logic           calc_exit;

   assign div_diff = acc_reg[2*N-1:N-1] - {1'b0, mplier_reg};

   always_comb begin
      acc_step = acc_reg;
      if (is_div_op(op_reg)) begin
         if (!div_diff[N])
            acc_step = {div_diff[N-1:0], acc_reg[N-2:0], 1'b1};
         else
            acc_step = {acc_reg[2*N-2:0], 1'b0};
      end else if (mplier_reg[0]) begin
         acc_step = acc_reg + mcand_reg;
      end
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign calc_exit = (count_reg == LAST_COUNT) ||
                      (!is_div_op(op_reg) && (mplier_reg[N-1:1] == '0));
`else
   assign calc_exit = (count_reg == LAST_COUNT);
`endif

   // Sign correction: the low-half carry chains into the high half only for the 2N-bit product.
   logic         hi_neg, lo_neg, hi_cin;
   logic [N-1:0] hi_fix, lo_fix;

   always_comb begin
      lo_neg = sdiff_reg;
      hi_neg = sdiff_reg;
      hi_cin = (acc_reg[N-1:0] == '0);
      if (is_div_op(op_reg)) begin
         hi_neg = aneg_reg;
         hi_cin = 1'b1;
      end
   end

   md_negate #(.W(N)) u_fix_lo (.value(acc_reg[N-1:0]),   .neg(lo_neg), .carry_in(1'b1),   .result(lo_fix));
   md_negate #(.W(N)) u_fix_hi (.value(acc_reg[2*N-1:N]), .neg(hi_neg), .carry_in(hi_cin), .result(hi_fix));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= MD_IDLE;
         count_reg  <= '0;
         op_reg     <= MD_MULT;
         sdiff_reg  <= 1'b0;
         aneg_reg   <= 1'b0;
         dz_reg     <= 1'b0;
         done_reg   <= 1'b0;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            MD_IDLE: begin
               if (hi_wen) hi_reg <= wd;
               if (lo_wen) lo_reg <= wd;
               if (start) begin
                  state_reg  <= MD_CALC;
                  count_reg  <= '0;
                  op_reg     <= op;
                  sdiff_reg  <= a_neg ^ b_neg;
                  aneg_reg   <= a_neg;
                  dz_reg     <= is_div_op(op) && (inB == '0);
                  mplier_reg <= mag_b;
                  if (is_div_op(op)) begin
                     acc_reg   <= {{N{1'b0}}, mag_a};
                     mcand_reg <= '0;
                  end else begin
                     acc_reg   <= '0;
                     mcand_reg <= {{N{1'b0}}, mag_a};
                  end
               end
            end
            MD_CALC: begin
               acc_reg   <= acc_step;
               count_reg <= count_reg + CW'(1);
               if (!is_div_op(op_reg)) begin
                  mcand_reg  <= mcand_reg << 1;
                  mplier_reg <= mplier_reg >> 1;
               end
               if (calc_exit) state_reg <= MD_FIX;
            end
            MD_FIX: begin
               hi_reg    <= hi_fix;
               lo_reg    <= dz_reg ? '1 : lo_fix;
               done_reg  <= 1'b1;
               state_reg <= MD_IDLE;
            end
            default: state_reg <= MD_IDLE;
         endcase
      end
   end

   assign busy = (state_reg != MD_IDLE);
   assign done = done_reg;
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (N=32): vector table plus handshake/reset sequences.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] inA = '0, inB = '0, wd = '0;
   logic        hi_wen = 1'b0, lo_wen = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   mul_div_unit #(.N(32), .CW(6)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .inA(inA), .inB(inB), .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected latency: early-out multiplies finish after (msb index of |b| + 1) iterations, at least one.
   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
      logic [31:0] m;
      int k;
      m = (o == MD_MULT && b[31]) ? (~b + 32'd1) : b;
      k = 1;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      return (o[1] || !EARLY) ? 34 : k + 2;
   endfunction

   // Drives start at the current negedge; returns at the negedge after the sampling edge.
   task automatic kick(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; inA = a; inB = b;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
      op = ~o; inA = ~a; inB = b ^ 32'h5A5A_A5A5;
   endtask

   task automatic wait_done(input string name, input int lat0, input int exp_l);
      int  lat;
      logic busy_ok;
      lat = lat0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      if (busy !== 1'b0) busy_ok = 1'b0;
      check({name, "_latency"}, 32'(lat), 32'(exp_l));
      check({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
      kick(o, a, b);
      wait_done(name, 1, exp_lat(o, b));
      check({name, "_hi"}, hi, ehi);
      check({name, "_lo"}, lo, elo);
      $display("%s op=%b a=%h b=%h -> hi=%h lo=%h", name, o, a, b, hi, lo);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int lat;
      int pulses;
      logic idle_ok;

      tbl[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      tbl[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      tbl[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3]  = '{MD_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
      tbl[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      tbl[5]  = '{MD_MULT,  32'd7,        32'd3,        32'h00000000, 32'd21};
      tbl[6]  = '{MD_DIVU,  32'd9,        32'd2,        32'd1,        32'd4};
      tbl[7]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      tbl[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      tbl[9]  = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      tbl[10] = '{MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};
      tbl[11] = '{MD_MULT,  32'd0,        32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      tbl[12] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
      tbl[13] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      tbl[14] = '{MD_DIV,   32'h80000000, 32'd2,        32'h00000000, 32'hC0000000};

      // Reset state
      repeat (2) @(negedge clock);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
      reset = 1'b1;
      @(negedge clock);

      // Table; each start after the first lands in the cycle done is high
      for (int i = 0; i < 15; i++)
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

      // start and hi_wen during busy are ignored
      kick(MD_DIVU, 32'd9, 32'd2);
      lat = 1;
      repeat (4) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      start = 1'b1; op = MD_MULTU; inA = 32'd100; inB = 32'd100;
      hi_wen = 1'b1; wd = 32'h0000DEAD;
      @(posedge clock);
      lat++;
      @(negedge clock);
      start = 1'b0; hi_wen = 1'b0;
      check("busy_hi_wen_ignored", hi, tbl[14].hi);
      wait_done("restart_ignored", lat, 34);
      check("restart_ignored_hi", hi, 32'd1);
      check("restart_ignored_lo", lo, 32'd4);
      $display("restart_ignored: hi=%h lo=%h", hi, lo);

      // done is a single-cycle pulse
      @(posedge clock);
      @(negedge clock);
      check("done_pulse_width", {31'b0, done}, 32'd0);

      // MTHI / MTLO in IDLE
      hi_wen = 1'b1; wd = 32'h0000DEAD;
      @(posedge clock);
      @(negedge clock);
      hi_wen = 1'b0;
      check("mthi_hi", hi, 32'h0000DEAD);
      check("mthi_lo_kept", lo, 32'd4);
      $display("mthi: hi=%h lo=%h", hi, lo);
      lo_wen = 1'b1; wd = 32'h0000BEEF;
      @(posedge clock);
      @(negedge clock);
      lo_wen = 1'b0;
      check("mtlo_lo", lo, 32'h0000BEEF);
      check("mtlo_hi_kept", hi, 32'h0000DEAD);
      $display("mtlo: hi=%h lo=%h", hi, lo);

      // Write together with start: write lands, result later overwrites it
      hi_wen = 1'b1; wd = 32'h00001234;
      kick(MD_MULTU, 32'd2, 32'd3);
      check("wen_with_start_hi", hi, 32'h00001234);
      wait_done("wen_with_start", 1, exp_lat(MD_MULTU, 32'd3));
      check("wen_with_start_res_hi", hi, 32'd0);
      check("wen_with_start_res_lo", lo, 32'd6);
      $display("wen_with_start: hi=%h lo=%h", hi, lo);

      // Asynchronous reset mid-operation (multiplier with a high msb keeps early-out busy)
      kick(MD_MULT, 32'd5, 32'h40000000);
      repeat (8) begin
         @(posedge clock);
         @(negedge clock);
      end
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      pulses = 0;
      idle_ok = 1'b1;
      repeat (40) begin
         @(posedge clock);
         @(negedge clock);
         if (done === 1'b1) pulses++;
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) idle_ok = 1'b0;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
      check("abort_stays_idle", {31'b0, idle_ok}, 32'd1);
      $display("reset_abort: busy=%b hi=%h lo=%h done_pulses=%0d", busy, hi, lo, pulses);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
